// File: rtl/wb_copy_master_pkg.sv
// ---------------------------------------------------------------------------
// wb_copy_master_pkg
// Shared Wishbone definitions for the word-copy master:
//   state_e      - copy FSM state encoding (IDLE, READ, WRITE, FIN)
//   WB_SEL_ALL   - all four byte lanes enabled
//   WORD_STRIDE  - byte distance between consecutive 32-bit words
//   word_align() - clears the two byte-offset bits of an address
// ---------------------------------------------------------------------------
package wb_copy_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_FIN   = 2'd3
    } state_e;

    localparam logic [3:0]  WB_SEL_ALL  = 4'hF;
    localparam logic [31:0] WORD_STRIDE = 32'd4;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/wb_copy_master_if.sv
// ---------------------------------------------------------------------------
// wb_copy_master_if
// Wishbone classic bus bundle between the copy master and a memory slave.
//   wb_addr  - byte address            (master -> slave)
//   wb_wdata - write data              (master -> slave)
//   wb_sel   - byte lane enables       (master -> slave)
//   wb_we    - write enable            (master -> slave)
//   wb_cyc   - bus cycle in progress   (master -> slave)
//   wb_stb   - strobe / valid access   (master -> slave)
//   wb_rdata - read data               (slave  -> master)
//   wb_ack   - one-cycle acknowledge   (slave  -> master)
// ---------------------------------------------------------------------------
interface wb_copy_master_if;

    logic [31:0] wb_addr;
    logic [31:0] wb_wdata;
    logic [3:0]  wb_sel;
    logic        wb_we;
    logic        wb_cyc;
    logic        wb_stb;
    logic [31:0] wb_rdata;
    logic        wb_ack;

    modport master (
        output wb_addr, wb_wdata, wb_sel, wb_we, wb_cyc, wb_stb,
        input  wb_rdata, wb_ack
    );

    modport slave (
        input  wb_addr, wb_wdata, wb_sel, wb_we, wb_cyc, wb_stb,
        output wb_rdata, wb_ack
    );

endinterface

// File: rtl/wb_copy_master.sv
// ---------------------------------------------------------------------------
// wb_copy_master
// Copies len_words 32-bit words from src_addr to dst_addr over a Wishbone
// bus, one read followed by one write per word. Every bus access is guarded
// by a wait counter; an access not acknowledged within TIMEOUT cycles, or an
// abort request, ends the copy with err=1.
//
// Ports
//   clk        - single clock, rising edge
//   reset_n    - synchronous, active-low reset
//   start      - one-cycle copy request, accepted only when idle
//   src_addr   - source byte address (bits [1:0] ignored)
//   dst_addr   - destination byte address (bits [1:0] ignored)
//   len_words  - number of words to copy (0 completes without bus traffic)
//   abort      - terminates an active copy at the next edge
//   busy       - copy in progress (cycle after accepted start .. done)
//   done       - one-cycle completion pulse
//   err        - valid with done: 1 = timeout or abort
//   wb         - Wishbone master port
// ---------------------------------------------------------------------------
module wb_copy_master
    import wb_copy_master_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [31:0]            src_addr,
    input  logic [31:0]            dst_addr,
    input  logic [15:0]            len_words,
    input  logic                   abort,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    wb_copy_master_if.master       wb
);

    localparam int unsigned WCW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    // Counter value seen on the last permitted wait cycle.
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);

    state_e          state_q, state_d;
    logic [31:0]     src_q,   src_d;
    logic [31:0]     dst_q,   dst_d;
    logic [15:0]     rem_q,   rem_d;
    logic [WCW-1:0]  wait_q,  wait_d;

    logic [31:0]     addr_q,  addr_d;
    logic [31:0]     wdata_q, wdata_d;   // doubles as the word buffer
    logic [3:0]      sel_q,   sel_d;
    logic            we_q,    we_d;
    logic            cyc_q,   cyc_d;
    logic            stb_q,   stb_d;
    logic            busy_q,  busy_d;
    logic            done_q,  done_d;
    logic            err_q,   err_d;

    // Next-state and next-output logic. All bus outputs are registered, so
    // they change only on the edge where a state transition happens.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        rem_d   = rem_q;
        wait_d  = wait_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        sel_d   = sel_q;
        we_d    = we_q;
        cyc_d   = cyc_q;
        stb_d   = stb_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    src_d  = word_align(src_addr);
                    dst_d  = word_align(dst_addr);
                    rem_d  = len_words;
                    wait_d = '0;
                    busy_d = 1'b1;
                    err_d  = 1'b0;
                    if (len_words != 16'd0) begin
                        state_d = ST_READ;
                        addr_d  = word_align(src_addr);
                        sel_d   = WB_SEL_ALL;
                        we_d    = 1'b0;
                        cyc_d   = 1'b1;
                        stb_d   = 1'b1;
                    end else begin
                        // Empty copy: straight to completion, no bus cycle.
                        state_d = ST_FIN;
                        done_d  = 1'b1;
                    end
                end
            end

            ST_READ, ST_WRITE: begin
                if (abort) begin
                    // Abort wins over a same-cycle ack, which is dropped.
                    state_d = ST_FIN;
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    we_d    = 1'b0;
                    sel_d   = '0;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else if (wb.wb_ack) begin
                    wait_d = '0;
                    if (state_q == ST_READ) begin
                        state_d = ST_WRITE;
                        wdata_d = wb.wb_rdata;
                        addr_d  = dst_q;
                        we_d    = 1'b1;
                    end else begin
                        rem_d = rem_q - 16'd1;
                        if (rem_q == 16'd1) begin
                            state_d = ST_FIN;
                            cyc_d   = 1'b0;
                            stb_d   = 1'b0;
                            we_d    = 1'b0;
                            sel_d   = '0;
                            done_d  = 1'b1;
                            err_d   = 1'b0;
                        end else begin
                            // cyc/stb stay high into the next read.
                            state_d = ST_READ;
                            src_d   = src_q + WORD_STRIDE;
                            dst_d   = dst_q + WORD_STRIDE;
                            addr_d  = src_q + WORD_STRIDE;
                            we_d    = 1'b0;
                        end
                    end
                end else if (wait_q == WAIT_LAST) begin
                    state_d = ST_FIN;
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    we_d    = 1'b0;
                    sel_d   = '0;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    wait_d = wait_q + WCW'(1);
                end
            end

            ST_FIN: begin
                // Acks arriving here are ignored; busy drops next cycle.
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                err_d   = 1'b0;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            wait_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            wait_q  <= wait_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            cyc_q   <= cyc_d;
            stb_q   <= stb_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign wb.wb_addr  = addr_q;
    assign wb.wb_wdata = wdata_q;
    assign wb.wb_sel   = sel_q;
    assign wb.wb_we    = we_q;
    assign wb.wb_cyc   = cyc_q;
    assign wb.wb_stb   = stb_q;

    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;

endmodule

// File: tb/tb_wb_copy_master.sv
module tb_wb_copy_master;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] src_addr = '0;
    logic [31:0] dst_addr = '0;
    logic [15:0] len_words = '0;
    logic        busy;
    logic        done;
    logic        err;

    wb_copy_master_if wb();

    wb_copy_master #(.TIMEOUT(8)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .len_words (len_words),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .wb        (wb)
    );

    always #5 clk = ~clk;

    // One-cycle-ack RAM responder (1 KiB window, byte addressed).
    // A transfer completes at the edge where ack and stb are both high.
    logic [31:0] mem [0:255];
    logic        resp_en = 1'b1;
    logic        ld_en = 1'b0;
    logic [7:0]  ld_idx = '0;
    logic [31:0] ld_dat = '0;
    logic [31:0] wr_addr_log [0:63];
    logic [31:0] rd_addr_log [0:63];
    int unsigned wr_cnt = 0;
    int unsigned rd_cnt = 0;

    always @(posedge clk) begin
        if (!reset_n) begin
            wb.wb_ack   <= 1'b0;
            wb.wb_rdata <= '0;
            for (int i = 0; i < 256; i++) mem[i] <= '0;
        end else begin
            if (ld_en) mem[ld_idx] <= ld_dat;
            if (wb.wb_ack && wb.wb_cyc && wb.wb_stb) begin
                if (wb.wb_we) begin
                    mem[wb.wb_addr[9:2]]      <= wb.wb_wdata;
                    wr_addr_log[wr_cnt[5:0]]  <= wb.wb_addr;
                    wr_cnt                    <= wr_cnt + 1;
                end else begin
                    rd_addr_log[rd_cnt[5:0]]  <= wb.wb_addr;
                    rd_cnt                    <= rd_cnt + 1;
                end
            end
            wb.wb_ack   <= resp_en && wb.wb_cyc && wb.wb_stb && !wb.wb_ack;
            wb.wb_rdata <= mem[wb.wb_addr[9:2]];
        end
    end

    // Reference memory image: what the RAM must hold after each copy.
    logic [31:0] model [0:255];
    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_word(input logic [7:0] idx, input logic [31:0] dat);
        ld_en  = 1'b1;
        ld_idx = idx;
        ld_dat = dat;
        model[idx] = dat;
        tick();
        ld_en = 1'b0;
    endtask

    // Start a copy, optionally pulse a conflicting start at cycle 'poke',
    // then check latency, status, bus writes and the memory image.
    task automatic run_copy(input string tag, input logic [31:0] s, input logic [31:0] d,
                            input logic [15:0] n, input int unsigned poke);
        int unsigned w0;
        int unsigned lat;
        logic [7:0]  si;
        logic [7:0]  di;
        w0 = wr_cnt;
        src_addr  = s;
        dst_addr  = d;
        len_words = n;
        start     = 1'b1;
        tick();
        start = 1'b0;
        lat = 1;
        check({tag, "_busy1"}, 32'(busy), 32'd1);
        if (n != 16'd0) begin
            check({tag, "_cyc1"},  32'(wb.wb_cyc), 32'd1);
            check({tag, "_stb1"},  32'(wb.wb_stb), 32'd1);
            check({tag, "_we1"},   32'(wb.wb_we),  32'd0);
            check({tag, "_sel1"},  32'(wb.wb_sel), 32'hF);
            check({tag, "_addr1"}, wb.wb_addr, {s[31:2], 2'b00});
        end else begin
            check({tag, "_nocyc"}, 32'(wb.wb_cyc), 32'd0);
        end
        while (!done && lat < 200) begin
            if (lat == poke) begin
                start = 1'b1; src_addr = '0; dst_addr = '0; len_words = 16'd7;
            end else begin
                start = 1'b0;
            end
            tick();
            lat++;
        end
        start = 1'b0;
        check({tag, "_latency"}, 32'(lat), 32'(4 * n + 1));
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_nwrites"}, 32'(wr_cnt - w0), 32'(n));
        for (int unsigned i = 0; i < n; i++) begin
            si = 8'(s[9:2] + 8'(i));
            di = 8'(d[9:2] + 8'(i));
            model[di] = model[si];
            check({tag, "_waddr"}, wr_addr_log[6'(w0 + i)], {d[31:2], 2'b00} + 32'(4 * i));
        end
        tick();
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_busy_off"}, 32'(busy), 32'd0);
        for (int unsigned i = 0; i < n; i++) begin
            di = 8'(d[9:2] + 8'(i));
            check({tag, "_mem"}, mem[di], model[di]);
        end
    endtask

    initial begin
        int unsigned c;
        int unsigned w0;
        int unsigned r0;
        int unsigned pulses;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] s;
        logic [31:0] d;
        logic [15:0] n;

        for (int i = 0; i < 256; i++) model[i] = '0;

        // Reset state
        reset_n = 1'b0;
        repeat (3) tick();
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_done",  32'(done), 32'd0);
        check("rst_err",   32'(err),  32'd0);
        check("rst_cyc",   32'(wb.wb_cyc), 32'd0);
        check("rst_stb",   32'(wb.wb_stb), 32'd0);
        check("rst_we",    32'(wb.wb_we),  32'd0);
        check("rst_sel",   32'(wb.wb_sel), 32'd0);
        check("rst_addr",  wb.wb_addr,  32'd0);
        check("rst_wdata", wb.wb_wdata, 32'd0);
        reset_n = 1'b1;
        tick();

        // Abort while idle must do nothing
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("idle_abort_busy", 32'(busy), 32'd0);
        check("idle_abort_done", 32'(done), 32'd0);

        // Directed 4-word copy 0x100 -> 0x200
        for (int unsigned k = 0; k < 4; k++) load_word(8'(64 + k), 32'h11111111 * (k + 1));
        run_copy("basic", 32'h0000_0100, 32'h0000_0200, 16'd4, 0);
        for (int unsigned k = 0; k < 4; k++)
            check("basic_const", mem[8'(128 + k)], 32'h11111111 * (k + 1));

        // Zero-length copy
        run_copy("len0", 32'h0000_0100, 32'h0000_0300, 16'd0, 0);

        // Randomized copies with unaligned addresses
        for (int t = 0; t < 4; t++) begin
            r1 = $urandom();
            r2 = $urandom();
            n  = 16'($urandom_range(1, 8));
            s  = {r1[31:10], 8'($urandom_range(0, 100)), r1[1:0]};
            d  = {r2[31:10], 8'($urandom_range(128, 240)), r2[1:0]};
            for (int unsigned k = 0; k < n; k++) load_word(8'(s[9:2] + 8'(k)), $urandom());
            run_copy("rand", s, d, n, 0);
        end

        // Timeout: responder silent
        resp_en = 1'b0;
        w0 = wr_cnt;
        src_addr = 32'h0000_0000; dst_addr = 32'h0000_0380; len_words = 16'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        c = 0;
        while (wb.wb_cyc && c < 50) begin
            tick();
            c++;
        end
        check("to_wait_cycles", 32'(c), 32'd8);
        check("to_done", 32'(done), 32'd1);
        check("to_err",  32'(err),  32'd1);
        check("to_nwrites", 32'(wr_cnt - w0), 32'd0);
        tick();
        check("to_busy_off", 32'(busy), 32'd0);
        resp_en = 1'b1;
        tick();

        // Abort during the second word's write phase
        for (int unsigned k = 0; k < 4; k++) load_word(8'(16 + k), $urandom());
        w0 = wr_cnt;
        src_addr = 32'h0000_0040; dst_addr = 32'h0000_02C0; len_words = 16'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        c = 0;
        while (!(wr_cnt == w0 + 1 && wb.wb_we && wb.wb_cyc) && c < 50) begin
            tick();
            c++;
        end
        check("ab_reached", 32'(c < 50), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ab_done", 32'(done), 32'd1);
        check("ab_err",  32'(err),  32'd1);
        check("ab_cyc",  32'(wb.wb_cyc), 32'd0);
        repeat (3) tick();
        check("ab_nwrites", 32'(wr_cnt - w0), 32'd1);
        check("ab_busy_off", 32'(busy), 32'd0);
        model[176] = model[16];
        check("ab_word0", mem[176], model[176]);
        check("ab_word1", mem[177], model[177]);

        // Next copy after abort proceeds normally
        run_copy("after_ab", 32'h0000_0044, 32'h0000_0340, 16'd3, 0);

        // Source wrap at 2^32 with a start pulse while busy
        load_word(8'd255, $urandom());
        load_word(8'd0,   $urandom());
        r0 = rd_cnt;
        run_copy("wrap", 32'hFFFF_FFFC, 32'h0000_0300, 16'd2, 3);
        check("wrap_rd0", rd_addr_log[6'(r0)],     32'hFFFF_FFFC);
        check("wrap_rd1", rd_addr_log[6'(r0 + 1)], 32'h0000_0000);
        check("wrap_nreads", 32'(rd_cnt - r0), 32'd2);

        // Reset during READ
        src_addr = 32'h0000_0100; dst_addr = 32'h0000_0200; len_words = 16'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        reset_n = 1'b0;
        tick();
        check("mr_cyc",   32'(wb.wb_cyc), 32'd0);
        check("mr_stb",   32'(wb.wb_stb), 32'd0);
        check("mr_busy",  32'(busy), 32'd0);
        check("mr_done",  32'(done), 32'd0);
        check("mr_err",   32'(err),  32'd0);
        check("mr_sel",   32'(wb.wb_sel), 32'd0);
        check("mr_addr",  wb.wb_addr,  32'd0);
        check("mr_wdata", wb.wb_wdata, 32'd0);
        reset_n = 1'b1;
        pulses = 0;
        repeat (6) begin
            tick();
            if (done) pulses++;
        end
        check("mr_no_done", 32'(pulses), 32'd0);
        check("mr_idle_cyc", 32'(wb.wb_cyc), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wb_copy_master.md
WB_COPY_MASTER -- requirements
Module: wb_copy_master

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum cycles one bus access may wait for wb_ack before abort.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 reset_n  input  1  reset; synchronous and active-low.
REQ-004 start  input  1  one-cycle request to begin a copy; sampled only when idle.
REQ-005 src_addr  input  32  source byte address, sampled on accepted start.
REQ-006 dst_addr  input  32  destination byte address, sampled on accepted start.
REQ-007 len_words  input  16  number of 32-bit words to copy, sampled on accepted start.
REQ-008 busy  output  1  high from the cycle after accepted start until done.
REQ-009 done  output  1  one-cycle pulse at completion, abort or timeout.
REQ-010 err  output  1  valid with done; 1 = timeout or abort, 0 = success.
REQ-011 abort  input  1  terminates the copy at the next edge.
REQ-012 wb_addr, wb_wdata  output  32 each  Wishbone byte address and write data.
REQ-013 wb_sel  output  4  byte lanes; wb_we, wb_cyc, wb_stb  output  1 each.
REQ-014 wb_rdata  input  32, wb_ack  input  1  Wishbone read data and acknowledge.

Function
REQ-015 FSM states: IDLE, READ, WRITE, FIN; IDLE is the only state accepting start.
REQ-016 IDLE + start + len_words!=0 -> READ; IDLE + start + len_words==0 -> FIN with no bus cycle.
REQ-017 Addresses are word-aligned: bits [1:0] of src_addr/dst_addr forced to 0; per-word increment +4, wrapping modulo 2^32.
REQ-018 READ: wb_cyc=wb_stb=1, wb_we=0, wb_sel=4'hF, wb_addr=current source; on wb_ack, latch wb_rdata into the word buffer and go to WRITE.
REQ-019 WRITE: wb_cyc=wb_stb=1, wb_we=1, wb_sel=4'hF, wb_addr=current destination, wb_wdata=buffer; on wb_ack, decrement remaining count.
REQ-020 After a write ack: remaining!=0 -> READ at the next addresses; remaining==0 -> FIN.
REQ-021 wb_cyc/wb_stb stay asserted across back-to-back accesses; address/we/wdata change only on the edge where wb_ack is sampled high.
REQ-022 Every wb_ack is one cycle; the master never counts a single ack twice; wb_ack in IDLE/FIN is ignored.
REQ-023 With a responder that acks one cycle after stb, each word takes exactly 4 cycles; first stb in the cycle after start.
REQ-024 Wait counter clears on entry to READ/WRITE and on every ack; reaching TIMEOUT -> FIN with err=1.
REQ-025 abort in READ/WRITE -> FIN with err=1 at the next edge; an ack in that same cycle is discarded (no count change).
REQ-026 FIN: wb_cyc=wb_stb=wb_we=0, done=1 for one cycle, busy=0 on the following cycle, -> IDLE.
REQ-027 start while busy is ignored; abort in IDLE has no effect.

Reset
REQ-028 On reset_n=0 at a clock edge: state IDLE, wb_cyc=wb_stb=wb_we=0, wb_sel=0, wb_addr=0, wb_wdata=0, busy=done=err=0, counters and buffer 0.
REQ-029 Reset mid-transfer drops wb_cyc/wb_stb at that edge with no done pulse.

Structure
REQ-030 A shared Wishbone package holds the FSM state encoding, WB_SEL_ALL=4'hF and the word stride constant 4.
REQ-031 No sub-module; the timeout counter lives inline.

Verification (bench uses a one-cycle-ack byte-addressed RAM responder)
REQ-032 src=0x100, dst=0x200, len=4, memory 0x11111111..0x44444444 -> copied to 0x200..0x20C; done at cycle 17 after start; err=0.
REQ-033 len=0 -> no wb_cyc; done pulse 1 cycle after start, err=0.
REQ-034 Responder never acks, TIMEOUT=8 -> wb_cyc falls after 8 wait cycles; done=1, err=1.
REQ-035 abort asserted during second word's WRITE -> exactly 1 word written; done=1, err=1; next start copies normally.
REQ-036 src=0xFFFFFFFC, len=2 -> second read at 0x00000000 (wrap); start pulsed while busy ignored.
REQ-037 reset_n low during READ -> wb_cyc=0 at the next edge, no done pulse, all outputs at reset values.
